// File: rtl/apb_initiator.sv
// APB requester: one command in, one SETUP/ACCESS transfer out, one response back; 4 cycles minimum from accept to the next req_ready.
// Backpressure: req_ready is high only in IDLE, and RESP holds the response until resp_ready.
module apb_initiator #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [2:0]  req_prot,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam bit         TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [7:0] WAIT_LAST  = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  prot_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [7:0]  wait_cnt;
    logic        timed_out;

    // A pready in the last allowed ACCESS cycle takes priority over the timeout.
    assign timed_out = TIMEOUT_EN && (wait_cnt == WAIT_LAST) && !out_pready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (out_pready || timed_out) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            prot_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        write_q <= req_write;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        prot_q  <= req_prot;
                    end
                end
                SETUP: wait_cnt <= '0;
                ACCESS: begin
                    if (out_pready) begin
                        rdata_q <= write_q ? 32'h0 : out_prdata;
                        err_q   <= out_pslverr;
                    end else if (timed_out) begin
                        rdata_q <= 32'h0;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes and selects decode straight from state so reset drops them immediately.
    assign req_ready   = (state == IDLE);
    assign out_psel    = (state == SETUP) || (state == ACCESS);
    assign out_penable = (state == ACCESS);
    assign resp_valid  = (state == RESP);
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign out_paddr   = addr_q;
    assign out_pwrite  = write_q;
    assign out_pwdata  = wdata_q;
    assign out_pprot   = prot_q;
    assign out_pstrb   = write_q ? wstrb_q : 4'b0000;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator: inputs driven and outputs sampled on the falling clock edge.
module tb_apb_initiator;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic [2:0]  req_prot = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] out_paddr;
    logic        out_psel;
    logic        out_penable;
    logic [2:0]  out_pprot;
    logic        out_pwrite;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;
    logic        out_pready = 1'b0;
    logic [31:0] out_prdata = '0;
    logic        out_pslverr = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    apb_initiator #(.TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .req_prot(req_prot),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
        .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
        .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr)
    );

    // Runs one command with resp_ready high; the completer raises pready in
    // ACCESS cycle rdy_at (0-based), or never when rdy_at is negative.
    task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [2:0] pr, input int rdy_at,
                          input logic slv, input logic [31:0] prd,
                          output int n_sel, output int n_en, output int n_tot,
                          output logic [3:0] strb, output logic ok,
                          output logic [31:0] rd, output logic er);
        n_sel = 0; n_en = 0; n_tot = 0; ok = 1'b1; strb = 4'hx; rd = 32'hx; er = 1'bx;
        resp_ready = 1'b1;
        out_pready = 1'b0;
        @(negedge clock);
        req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = wd;
        req_wstrb = ws; req_prot = pr;
        do begin
            @(negedge clock);
            n_tot++;
            req_valid = 1'b0;
            out_pready = 1'b0; out_pslverr = 1'b0; out_prdata = 32'hA5A5_5A5A;
            if (out_penable && !out_psel) ok = 1'b0;
            if (out_psel && resp_valid) ok = 1'b0;
            if (out_psel) begin
                if (n_sel == 0) strb = out_pstrb;
                if (out_paddr !== a || out_pwrite !== w || out_pwdata !== wd ||
                    out_pprot !== pr || out_pstrb !== strb) ok = 1'b0;
                n_sel++;
            end
            if (out_penable) begin
                if (n_en == rdy_at) begin
                    out_pready = 1'b1; out_pslverr = slv; out_prdata = prd;
                end
                n_en++;
            end
            if (resp_valid) begin
                rd = resp_rdata; er = resp_err;
            end
        end while (!req_ready && n_tot < 100);
        out_pready = 1'b0; out_pslverr = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        tests++;
        if ({out_psel, out_penable, resp_valid, resp_err} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: psel/penable/resp_valid/err=%b expected 0000",
                     {out_psel, out_penable, resp_valid, resp_err});
        end
        tests++;
        if ({resp_rdata, out_paddr, out_pwdata, out_pstrb, out_pprot, out_pwrite} !== '0) begin
            fails++;
            $display("FAIL reset_data: rdata=%h paddr=%h pwdata=%h pstrb=%h pprot=%h pwrite=%b expected all 0",
                     resp_rdata, out_paddr, out_pwdata, out_pstrb, out_pprot, out_pwrite);
        end
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_write_basic;
        int ns, ne, nt; logic [3:0] st; logic ok; logic [31:0] rd; logic er;
        do_txn(32'h0, 1'b1, 32'h0000_00A5, 4'hF, 3'd2, 0, 1'b0, 32'hDEAD_BEEF,
               ns, ne, nt, st, ok, rd, er);
        tests++;
        if (ns !== 2 || ne !== 1) begin
            fails++; $display("FAIL write_timing: psel=%0d penable=%0d cycles expected 2/1", ns, ne);
        end
        tests++;
        if (st !== 4'hF || ok !== 1'b1) begin
            fails++; $display("FAIL write_bus: pstrb=%h ok=%b expected F/1", st, ok);
        end
        tests++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            fails++; $display("FAIL write_resp: rdata=%h err=%b expected 0/0", rd, er);
        end
        tests++;
        if (nt !== 4) begin
            fails++; $display("FAIL min_cost: %0d cycles accept to req_ready expected 4", nt);
        end
    endtask

    task automatic test_read_wait;
        int ns, ne, nt; logic [3:0] st; logic ok; logic [31:0] rd; logic er;
        do_txn(32'h4, 1'b0, 32'h1111_2222, 4'hC, 3'd5, 3, 1'b0, 32'h0000_BEEF,
               ns, ne, nt, st, ok, rd, er);
        tests++;
        if (ne !== 4 || ns !== 5) begin
            fails++; $display("FAIL read_wait_timing: penable=%0d psel=%0d expected 4/5", ne, ns);
        end
        tests++;
        if (st !== 4'h0 || ok !== 1'b1) begin
            fails++; $display("FAIL read_bus: pstrb=%h ok=%b expected 0/1", st, ok);
        end
        tests++;
        if (rd !== 32'h0000_BEEF || er !== 1'b0) begin
            fails++; $display("FAIL read_resp: rdata=%h err=%b expected 0000beef/0", rd, er);
        end
    endtask

    task automatic test_slverr;
        int ns, ne, nt; logic [3:0] st; logic ok; logic [31:0] rd; logic er;
        do_txn(32'hC, 1'b1, 32'hCAFE_0001, 4'h3, 3'd1, 1, 1'b1, 32'h7777_7777,
               ns, ne, nt, st, ok, rd, er);
        tests++;
        if (er !== 1'b1 || rd !== 32'h0 || st !== 4'h3 || ne !== 2) begin
            fails++; $display("FAIL slverr: err=%b rdata=%h pstrb=%h penable=%0d expected 1/0/3/2",
                              er, rd, st, ne);
        end
    endtask

    task automatic test_timeout;
        int ns, ne, nt; logic [3:0] st; logic ok; logic [31:0] rd; logic er;
        do_txn(32'h10, 1'b0, 32'h0, 4'h0, 3'd0, -1, 1'b0, 32'h0,
               ns, ne, nt, st, ok, rd, er);
        tests++;
        if (ne !== 16 || er !== 1'b1 || rd !== 32'h0 || ok !== 1'b1) begin
            fails++; $display("FAIL timeout: access=%0d err=%b rdata=%h ok=%b expected 16/1/0/1",
                              ne, er, rd, ok);
        end
        do_txn(32'h14, 1'b0, 32'h0, 4'h0, 3'd0, 15, 1'b0, 32'h0000_0055,
               ns, ne, nt, st, ok, rd, er);
        tests++;
        if (ne !== 16 || er !== 1'b0 || rd !== 32'h0000_0055) begin
            fails++; $display("FAIL ready_in_timeout_cycle: access=%0d err=%b rdata=%h expected 16/0/00000055",
                              ne, er, rd);
        end
    endtask

    task automatic test_back_to_back;
        int guard;
        resp_ready = 1'b0;
        @(negedge clock);
        req_valid = 1'b1; req_addr = 32'h8; req_write = 1'b0; req_wdata = 32'h0;
        req_wstrb = 4'h0; req_prot = 3'd0;
        @(negedge clock);
        req_addr = 32'h20;
        tests++;
        if (req_ready !== 1'b0 || out_psel !== 1'b1) begin
            fails++; $display("FAIL b2b_setup: req_ready=%b psel=%b expected 0/1", req_ready, out_psel);
        end
        @(negedge clock);
        out_pready = 1'b1; out_prdata = 32'h1234_5678;
        @(negedge clock);
        out_pready = 1'b0; out_prdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h1234_5678 || resp_err !== 1'b0 ||
                req_ready !== 1'b0 || out_psel !== 1'b0) begin
                fails++;
                $display("FAIL resp_hold[%0d]: valid=%b rdata=%h err=%b req_ready=%b psel=%b expected 1/12345678/0/0/0",
                         i, resp_valid, resp_rdata, resp_err, req_ready, out_psel);
            end
            if (i < 4) @(negedge clock);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_idle: req_ready=%b resp_valid=%b expected 1/0", req_ready, resp_valid);
        end
        @(negedge clock);
        req_valid = 1'b0;
        tests++;
        if (out_psel !== 1'b1 || out_paddr !== 32'h20) begin
            fails++; $display("FAIL b2b_second: psel=%b paddr=%h expected 1/00000020", out_psel, out_paddr);
        end
        out_pready = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        out_pready = 1'b0;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_drain: req_ready=%b after %0d cycles expected 1", req_ready, guard);
        end
    endtask

    task automatic test_reset_mid_access;
        int ns, ne, nt; logic [3:0] st; logic ok; logic [31:0] rd; logic er;
        logic seen_valid;
        @(negedge clock);
        req_valid = 1'b1; req_addr = 32'h30; req_write = 1'b1; req_wdata = 32'h5;
        req_wstrb = 4'hF; req_prot = 3'd3;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        tests++;
        if (out_penable !== 1'b1) begin
            fails++; $display("FAIL rst_mid_pre: penable=%b expected 1", out_penable);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (out_psel !== 1'b0 || out_penable !== 1'b0 || resp_valid !== 1'b0) begin
            fails++; $display("FAIL rst_mid_drop: psel=%b penable=%b resp_valid=%b expected 0/0/0",
                              out_psel, out_penable, resp_valid);
        end
        @(negedge clock);
        reset = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (resp_valid || out_psel) seen_valid = 1'b1;
        end
        tests++;
        if (req_ready !== 1'b1 || seen_valid !== 1'b0 || out_paddr !== 32'h0) begin
            fails++; $display("FAIL rst_mid_after: req_ready=%b activity=%b paddr=%h expected 1/0/0",
                              req_ready, seen_valid, out_paddr);
        end
        do_txn(32'h40, 1'b0, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'h0BAD_F00D,
               ns, ne, nt, st, ok, rd, er);
        tests++;
        if (rd !== 32'h0BAD_F00D || er !== 1'b0 || nt !== 4) begin
            fails++; $display("FAIL rst_recover: rdata=%h err=%b cycles=%0d expected 0badf00d/0/4", rd, er, nt);
        end
    endtask

    initial begin
        test_reset;
        test_write_basic;
        test_read_wait;
        test_slverr;
        test_timeout;
        test_back_to_back;
        test_reset_mid_access;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
